// File: rtl/sample_averager_fifo_if.sv
// Capture and output-word handshake bundle for the sample averager.
// The environment drives the master side; the averager is the slave.
interface sample_averager_fifo_if #(
  parameter int WIDTH = 8
);
  logic             capture;
  logic [WIDTH-1:0] count_true;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output capture, count_true, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  capture, count_true, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/sample_averager_fifo.sv
// Drops settling captures, averages groups of 2^AVG_LOG2 samples
// and queues the averaged words in a small FIFO with a sticky overflow flag.
module sample_averager_fifo #(
  parameter int WIDTH    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int DEPTH    = 4,
  parameter int DISCARD  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr_ovf,
  sample_averager_fifo_if.slave    bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int ACCW = WIDTH + AVG_LOG2;
  localparam int CW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DW   = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM
  } state_t;

  state_t           state_q, state_d, cur;
  logic             capture_d_q, capture_d_d;
  logic [ACCW-1:0]  acc_q, acc_d, acc_sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    disc_q, disc_d;
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             take, push, pop, wr_en, full, valid;
  logic [WIDTH-1:0] push_word;

  assign valid = (level_q != '0);
  assign full  = (level_q == FULL_LVL);
  assign pop   = valid & bus.out_ready;
  assign take  = capture_d_q & en;

  always_comb begin
    capture_d_d = bus.capture;
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    disc_d      = disc_q;
    push        = 1'b0;
    push_word   = '0;
    acc_sum     = acc_q + ACCW'(bus.count_true);
    // A sample arriving in the enable cycle already counts toward settling.
    cur         = state_q;
    if (state_q == IDLE) cur = (DISCARD == 0) ? ACCUM : SETTLE;

    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      disc_d  = '0;
    end else begin
      state_d = cur;
      if (take) begin
        unique case (1'b1)
          (cur == SETTLE): begin
            if (disc_q == DISC_LAST) begin
              disc_d  = '0;
              state_d = ACCUM;
            end else begin
              disc_d = disc_q + 1'b1;
            end
          end
          (cur == ACCUM): begin
            if (cnt_q == CNT_LAST) begin
              push      = 1'b1;
              push_word = WIDTH'(acc_sum >> AVG_LOG2);
              acc_d     = '0;
              cnt_d     = '0;
            end else begin
              acc_d = acc_sum;
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    // A pop frees the slot the full-FIFO push needs in the same edge.
    wr_en   = push & (~full | pop);
    if (wr_en) begin
      mem_d[wr_q] = push_word;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    level_d = level_q + LW'(wr_en) - LW'(pop);
    if (push & ~wr_en) ovf_d = 1'b1;
    else if (clr_ovf)  ovf_d = 1'b0;
    else               ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      capture_d_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      disc_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      capture_d_q <= capture_d_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      disc_q      <= disc_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? mem_q[rd_q] : '0;
  assign level         = level_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_sample_averager_fifo.sv
// Scenario and randomized checks of sample_averager_fifo against
// a queue-based model of drop/average/FIFO behaviour.
module tb_sample_averager_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int DS = 1;
  localparam int N  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clr_ovf;
  logic [2:0] level;
  logic       overflow;

  sample_averager_fifo_if #(.WIDTH(W)) sif();

  sample_averager_fifo #(
    .WIDTH(W), .AVG_LOG2(2), .DEPTH(D), .DISCARD(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_ovf(clr_ovf),
    .bus(sif.slave), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  int mq[$];
  int grp[$];
  int m_disc;
  bit m_ovf;
  bit m_cap;

  task automatic model_reset();
    mq.delete();
    grp.delete();
    m_disc = DS;
    m_ovf  = 1'b0;
    m_cap  = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model at the posedge.
  task automatic step(input bit c, input int ct, input bit rdy,
                      input bit clr = 1'b0);
    int sz, s, w;
    bit pop, push;
    sif.capture    = c;
    sif.count_true = ct[W-1:0];
    sif.out_ready  = rdy;
    clr_ovf        = clr;
    @(posedge clk);
    sz   = mq.size();
    pop  = (sz > 0) && rdy;
    push = 1'b0;
    w    = 0;
    if (!en) begin
      m_disc = DS;
      grp.delete();
    end else if (m_cap) begin
      if (m_disc > 0) m_disc--;
      else begin
        grp.push_back(ct);
        if (grp.size() == N) begin
          s = 0;
          foreach (grp[k]) s += grp[k];
          w    = s / N;
          push = 1'b1;
          grp.delete();
        end
      end
    end
    m_cap = c;
    if (pop) void'(mq.pop_front());
    if (push && sz == D && !pop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (push && !(sz == D && !pop)) mq.push_back(w);
    @(negedge clk);
  endtask

  task automatic cap(input int v, input bit rdy_last = 1'b0,
                     input bit clr_last = 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b0, v, rdy_last, clr_last);
  endtask

  task automatic group(input int v);
    for (int i = 0; i < N; i++) cap(v);
  endtask

  task automatic test_reset();
    checks++;
    if (sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%0b want=0", sif.out_valid);
    end
    checks++;
    if (level !== 3'd0) begin
      failures++;
      $display("FAIL reset_level got=%0d want=0", level);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%0b want=0", overflow);
    end
    checks++;
    if (sif.out_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_data got=%0d want=0", sif.out_data);
    end
  endtask

  task automatic test_basic();
    en = 1'b1;
    step(1'b0, 0, 1'b0);
    cap(99);
    cap(10);
    cap(20);
    cap(30);
    step(1'b1, 0, 1'b0);
    checks++;
    if (sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid got=%0b want=0", sif.out_valid);
    end
    step(1'b0, 41, 1'b0);
    checks++;
    if (sif.out_valid !== 1'b1 || sif.out_data !== 8'd25) begin
      failures++;
      $display("FAIL basic_word got=%0b/%0d want=1/25",
               sif.out_valid, sif.out_data);
    end
    checks++;
    if (level !== 3'd1) begin
      failures++;
      $display("FAIL basic_level got=%0d want=1", level);
    end
    step(1'b0, 0, 1'b1);
    checks++;
    if (level !== 3'd0 || sif.out_data !== 8'd0) begin
      failures++;
      $display("FAIL basic_pop got=%0d/%0d want=0/0", level, sif.out_data);
    end
  endtask

  task automatic test_max();
    group(255);
    checks++;
    if (sif.out_data !== 8'd255 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL max_word got=%0d/%0b want=255/0",
               sif.out_data, overflow);
    end
    step(1'b0, 0, 1'b1);
  endtask

  task automatic test_overflow();
    for (int g = 0; g < 5; g++) group(8);
    group(16);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state got=%0d/%0b want=4/1", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data !== 8'd8) begin
        failures++;
        $display("FAIL ovf_pop%0d got=%0d want=8", i, sif.out_data);
      end
      step(1'b0, 0, 1'b1);
    end
    checks++;
    if (level !== 3'd0 || sif.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain got=%0d/%0b want=0/0", level, sif.out_valid);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%0b want=0", overflow);
    end
  endtask

  task automatic test_full_pop();
    int exp_w[4];
    exp_w = '{2, 3, 4, 9};
    for (int v = 1; v <= 4; v++) group(v);
    for (int i = 0; i < 3; i++) cap(9);
    cap(9, 1'b1);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_state got=%0d/%0b want=4/0", level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data !== exp_w[i][7:0]) begin
        failures++;
        $display("FAIL fullpop_order%0d got=%0d want=%0d",
                 i, sif.out_data, exp_w[i]);
      end
      step(1'b0, 0, 1'b1);
    end
  endtask

  task automatic test_en_drop();
    cap(100);
    cap(100);
    en = 1'b0;
    step(1'b0, 0, 1'b0);
    en = 1'b1;
    step(1'b0, 0, 1'b0);
    cap(200);
    cap(4);
    cap(8);
    cap(12);
    checks++;
    if (level !== 3'd0) begin
      failures++;
      $display("FAIL endrop_nopush got=%0d want=0", level);
    end
    cap(16);
    checks++;
    if (level !== 3'd1 || sif.out_data !== 8'd10) begin
      failures++;
      $display("FAIL endrop_word got=%0d/%0d want=1/10",
               level, sif.out_data);
    end
    step(1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int v = 1; v <= 5; v++) group(v);
    step(1'b0, 0, 1'b1);
    cap(50);
    cap(50);
    checks++;
    if (level !== 3'd3 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre got=%0d/%0b want=3/1", level, overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sif.out_valid, level, overflow, sif.out_data} !== 13'd0) begin
      failures++;
      $display("FAIL rstmid_async got=%0b/%0d/%0b/%0d want=0/0/0/0",
               sif.out_valid, level, overflow, sif.out_data);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cap(60);
    cap(20);
    cap(20);
    cap(20);
    checks++;
    if (level !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_fresh got=%0d want=0", level);
    end
    cap(20);
    checks++;
    if (level !== 3'd1 || sif.out_data !== 8'd20) begin
      failures++;
      $display("FAIL rstmid_word got=%0d/%0d want=1/20",
               level, sif.out_data);
    end
    for (int v = 1; v <= 3; v++) group(v);
    for (int i = 0; i < 3; i++) cap(7);
    cap(7, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL setclr_ovf got=%0b want=1", overflow);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_after got=%0b want=0", overflow);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [12:0] got, want;
    int m_data;
    bit rdy;
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 29) != 0);
      rdy = ($urandom_range(0, 99) < ((i < 1500) ? 20 : 70));
      step(($urandom_range(0, 2) == 0), $urandom_range(0, 255), rdy,
           ($urandom_range(0, 15) == 0));
      m_data = (mq.size() > 0) ? mq[0] : 0;
      want = {(mq.size() > 0), m_data[7:0], 3'(mq.size()), m_ovf};
      got  = {sif.out_valid, sif.out_data, level, overflow};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_cyc%0d got=%h want=%h", i, got, want);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    clr_ovf  = 1'b0;
    sif.capture    = 1'b0;
    sif.count_true = '0;
    sif.out_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_max();
    test_overflow();
    test_full_pop();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sample_averager_fifo.md
SAMPLE_AVERAGER_FIFO -- requirements
Module: sample_averager_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of captured counts and of averaged output words.
REQ-002 SHALL have parameter AVG_LOG2, default 2, where 2^AVG_LOG2 samples are averaged per output word.
REQ-003 SHALL have parameter DEPTH, default 4, the output FIFO depth in words, a power of two and at least 2.
REQ-004 SHALL have parameter DISCARD, default 1, the number of captures dropped after each enable before accumulation starts.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  enable; low holds the block idle.
REQ-008 capture  input  1  one-cycle strobe from the upstream sampler marking a new capture; count_true is valid the following cycle.
REQ-009 count_true  input  WIDTH  captured counter value from the upstream sampler.
REQ-010 out_data  output  WIDTH  FIFO head word, valid only while out_valid is high.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  consumer accepts the head word.
REQ-013 level  output  clog2(DEPTH)+1  FIFO occupancy, from 0 to DEPTH.
REQ-014 overflow  output  1  sticky flag: an averaged word was dropped.
REQ-015 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-016 SHALL register capture into capture_d and accept a sample, taking count_true, in each cycle where capture_d=1 and en=1.
REQ-017 SHALL implement FSM IDLE, SETTLE and ACCUM.
- IDLE to SETTLE when en=1; if DISCARD=0, IDLE goes directly to ACCUM.
- SETTLE to ACCUM on the DISCARD-th accepted sample.
- Any state to IDLE in the cycle where en=0.
REQ-018 In SETTLE, SHALL count and drop accepted samples without accumulating them.
REQ-019 In ACCUM, SHALL add each accepted sample to an accumulator of width WIDTH+AVG_LOG2 and increment a sample counter.
- The accumulator SHALL never wrap.
REQ-020 On the 2^AVG_LOG2-th sample, SHALL push (accumulator + sample) >> AVG_LOG2 (truncating) into the FIFO at that same edge, clear the accumulator and counter, and remain in ACCUM.
REQ-021 Entering IDLE SHALL discard any partial accumulation and discard count; FIFO contents SHALL be retained.
REQ-022 Latency: out_valid SHALL rise 2 cycles after the capture strobe of the last sample of a group, provided the FIFO was empty.
REQ-023 Pop SHALL occur on any edge where out_valid=1 and out_ready=1; out_data SHALL then present the next word, in FIFO order, in the following cycle.
REQ-024 out_ready while empty SHALL have no effect.
REQ-025 A push to a full FIFO with a simultaneous pop SHALL be accepted and leave level unchanged with no overflow.
REQ-026 A push to a full FIFO without a pop SHALL drop the new word, leave contents unchanged, and set overflow.
REQ-027 A push and pop on a non-full, non-empty FIFO SHALL leave level unchanged.
REQ-028 overflow SHALL clear on clr_ovf=1; a simultaneous set and clr_ovf SHALL leave overflow=1.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force:
- FSM to IDLE, with capture_d, accumulator, sample counter, discard counter and both pointers at 0;
- level=0, out_valid=0, out_data=0, overflow=0.
REQ-032 Reset asserted mid-group or mid-handshake SHALL discard all data; after release, the first push SHALL require DISCARD plus 2^AVG_LOG2 fresh accepted samples.

Verification (WIDTH=8, AVG_LOG2=2, DEPTH=4, DISCARD=1)
REQ-033 en=1, captures with count_true 99, 10, 20, 30, 41 -> 99 dropped; out_data=25 (101>>2); out_valid high 2 cycles after the capture of 41; level=1.
REQ-034 four captures of 255 -> out_data=255, overflow=0.
REQ-035 out_ready=0, 5 groups of four 8s, then four 16s -> level=4, overflow=1, pops return 8, 8, 8, 8 in order; the 16 word is lost.
REQ-036 FIFO full; the last sample of a group lands in a cycle with out_ready=1 -> level stays 4, overflow stays 0, the new word appears at the tail.
REQ-037 en dropped after 2 of 4 samples, then re-raised -> no push occurs; the first capture after re-enable is discarded; the next 4 captures produce one word.
REQ-038 rst_n pulsed low while level=3 and overflow=1 -> out_valid=0, level=0, overflow=0 asynchronously; clr_ovf and set in the same cycle -> overflow=1.
